// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point constants for the accumulator and the fixed-to-float stage that follows it.
package nn_fixed_pkg;

  // Accumulator width. The downstream converter input width must match it.
  localparam int ACC_WIDTH = 43;

  // Symmetric saturation bounds. The most-negative code is excluded so that the
  // sign/magnitude conversion downstream never has to represent +2^42.
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX     = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN_SYM = -ACC_MAX;

  // Depth of the free-running fixed-to-float pipeline. Consumers delay
  // out_valid by this many cycles to stay aligned with its results.
  localparam int F2F_LATENCY = 6;

endpackage

// File: rtl/fixed_accumulator_if.sv
// Term/result bus between the product source, the accumulator and its consumer.
interface fixed_accumulator_if #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = nn_fixed_pkg::ACC_WIDTH
);
  logic                        in_valid;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_last;
  logic signed [ACC_WIDTH-1:0] bias_in;
  logic                        flush;
  logic signed [ACC_WIDTH-1:0] fixed_out;
  logic                        out_valid;
  logic                        sat_flag;
  logic                        busy;

  // The term source drives the inputs and observes the results.
  modport master (
    output in_valid, in_data, in_last, bias_in, flush,
    input  fixed_out, out_valid, sat_flag, busy
  );

  // The accumulator consumes the terms and produces the results.
  modport slave (
    input  in_valid, in_data, in_last, bias_in, flush,
    output fixed_out, out_valid, sat_flag, busy
  );
endinterface

// File: rtl/fixed_sat_adder.sv
// Combinational signed adder with symmetric saturation to [-(2^(W-1)-1), 2^(W-1)-1].
module fixed_sat_adder
  import nn_fixed_pkg::*;
#(
  parameter int W = ACC_WIDTH
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W:0]   MAX_WIDE = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0]   MIN_WIDE = -MAX_WIDE;
  localparam logic signed [W-1:0] MAX_SAT  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_SAT  = -MAX_SAT;

  logic signed [W:0] wide_sum;

  // One extra bit holds any true sum; the most-negative code also clamps and counts as overflow.
  always_comb begin
    wide_sum = $signed({a[W-1], a}) + $signed({b[W-1], b});
    sum      = wide_sum[W-1:0];
    ovf      = 1'b0;
    if (wide_sum > MAX_WIDE) begin
      sum = MAX_SAT;
      ovf = 1'b1;
    end else if (wide_sum < MIN_WIDE) begin
      sum = MIN_SAT;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_accumulator.sv
// Two-stage signed group accumulator: input register, then bias/accumulate with saturation.
module fixed_accumulator
  import nn_fixed_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = nn_fixed_pkg::ACC_WIDTH
) (
  input logic               clk,
  input logic               reset_n,
  fixed_accumulator_if.slave bus
);

  // Stage 0 registers
  logic                        s0_valid_reg;
  logic signed [ACC_WIDTH-1:0] s0_data_reg;
  logic                        s0_last_reg;
  logic                        s0_first_reg;
  logic signed [ACC_WIDTH-1:0] s0_bias_reg;
  logic                        first_reg;

  // Stage 1 registers
  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic                        sticky_reg;
  logic signed [ACC_WIDTH-1:0] fixed_out_reg;
  logic                        sat_flag_reg;
  logic                        out_valid_reg;

  logic signed [ACC_WIDTH-1:0] base_next;
  logic signed [ACC_WIDTH-1:0] sum_next;
  logic                        ovf_next;
  logic                        sticky_next;
  logic                        s1_fire;

  // Stage 0: capture accepted terms; flush wipes the pipeline entry and re-arms first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_reg <= 1'b0;
      s0_data_reg  <= '0;
      s0_last_reg  <= 1'b0;
      s0_first_reg <= 1'b0;
      s0_bias_reg  <= '0;
      first_reg    <= 1'b1;
    end else if (bus.flush) begin
      s0_valid_reg <= 1'b0;
      first_reg    <= 1'b1;
    end else begin
      s0_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s0_data_reg  <= {{(ACC_WIDTH-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
        s0_last_reg  <= bus.in_last;
        s0_first_reg <= first_reg;
        s0_bias_reg  <= bus.bias_in;
        first_reg    <= bus.in_last;
      end
    end
  end

  // A term sitting in stage 0 at a flush edge is discarded along with its group.
  assign s1_fire     = s0_valid_reg & ~bus.flush;
  assign base_next   = s0_first_reg ? s0_bias_reg : acc_reg;
  assign sticky_next = (s0_first_reg ? 1'b0 : sticky_reg) | ovf_next;

  fixed_sat_adder #(
    .W (ACC_WIDTH)
  ) u_sat_adder (
    .a   (base_next),
    .b   (s0_data_reg),
    .sum (sum_next),
    .ovf (ovf_next)
  );

  // Stage 1: accumulate, track sticky saturation, publish the result on the last term.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      sticky_reg    <= 1'b0;
      fixed_out_reg <= '0;
      sat_flag_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (bus.flush) begin
        sticky_reg <= 1'b0;
      end else if (s1_fire) begin
        acc_reg    <= sum_next;
        sticky_reg <= sticky_next;
        if (s0_last_reg) begin
          fixed_out_reg <= sum_next;
          sat_flag_reg  <= sticky_next;
          out_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.fixed_out = fixed_out_reg;
  assign bus.sat_flag  = sat_flag_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = ~first_reg | s0_valid_reg;

endmodule

// File: tb/tb_fixed_accumulator.sv
// Self-checking bench for fixed_accumulator: vector table plus hand-written corner sequences.
module tb_fixed_accumulator;
  import nn_fixed_pkg::*;

  localparam int IW = 32;
  localparam int AW = 43;

  logic clk;
  logic reset_n;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    longint fixed;
    logic   sat;
    int     due;
  } exp_t;

  typedef struct {
    logic   v;
    longint d;
    logic   l;
    longint b;
    longint exp_fixed;
    logic   exp_sat;
  } vec_t;

  exp_t scb[$];
  vec_t vecs[12];

  fixed_accumulator_if #(.IN_WIDTH(IW), .ACC_WIDTH(AW)) bus ();

  fixed_accumulator #(
    .IN_WIDTH  (IW),
    .ACC_WIDTH (AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: every pulse must match the oldest expectation, in the expected cycle.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid) begin
      if (scb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got fixed_out=%0d expected no pulse (cycle %0d)",
                 bus.fixed_out, cyc);
      end else begin
        exp_t e;
        e = scb.pop_front();
        chk("fixed_out", longint'(bus.fixed_out), e.fixed);
        chk("sat_flag", longint'(bus.sat_flag), longint'(e.sat));
        chk("latency", longint'(cyc), longint'(e.due));
        $display("result: fixed_out=%0d sat_flag=%0b cycle=%0d", bus.fixed_out, bus.sat_flag, cyc);
      end
    end
  end

  // One input cycle; a valid last term that is not flushed queues its expected result.
  task automatic beat(input logic v, input longint d, input logic l, input longint b,
                      input logic f, input longint exp_fixed, input logic exp_sat);
    exp_t e;
    bus.in_valid = v;
    bus.in_data  = d[IW-1:0];
    bus.in_last  = l;
    bus.bias_in  = b[AW-1:0];
    bus.flush    = f;
    @(posedge clk);
    #1;
    if (v && l && !f) begin
      e.fixed = exp_fixed;
      e.sat   = exp_sat;
      e.due   = cyc + 1;
      scb.push_back(e);
    end
    $display("beat: v=%0b data=%0d last=%0b bias=%0d flush=%0b", v, d, l, b, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (scb.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #1;
    chk("drain_pending", longint'(scb.size()), 0);
  endtask

  initial begin
    cyc   = 0;
    total = 0;
    bad   = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.bias_in  = '0;
    bus.flush    = 1'b0;

    vecs[0]  = '{1'b1, 100, 1'b0, 10, 0, 1'b0};
    vecs[1]  = '{1'b1, 200, 1'b0, 0, 0, 1'b0};
    vecs[2]  = '{1'b1, -50, 1'b1, 0, 260, 1'b0};
    vecs[3]  = '{1'b1, 5, 1'b1, 1, 6, 1'b0};
    vecs[4]  = '{1'b1, 2, 1'b1, -3, -1, 1'b0};
    vecs[5]  = '{1'b1, -7, 1'b1, 0, -7, 1'b0};
    vecs[6]  = '{1'b1, 1, 1'b0, longint'(ACC_MAX), 0, 1'b0};
    vecs[7]  = '{1'b1, -1, 1'b1, 0, longint'(ACC_MAX) - 1, 1'b1};
    vecs[8]  = '{1'b1, -5, 1'b1, longint'(ACC_MIN_SYM), longint'(ACC_MIN_SYM), 1'b1};
    vecs[9]  = '{1'b1, 7, 1'b1, 3, 10, 1'b0};
    vecs[10] = '{1'b1, 1, 1'b0, longint'(ACC_MIN_SYM), 0, 1'b0};
    vecs[11] = '{1'b1, -2, 1'b1, 0, longint'(ACC_MIN_SYM), 1'b1};

    // Reset state
    reset_n = 1'b0;
    #12;
    chk("rst_fixed_out", longint'(bus.fixed_out), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_sat_flag", longint'(bus.sat_flag), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Table: basic group, back-to-back single terms, saturation both ways, clean group.
    for (int i = 0; i < 12; i++)
      beat(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].b, 1'b0, vecs[i].exp_fixed, vecs[i].exp_sat);
    idle(1);
    drain();

    // Flush with the last term on the same cycle: group dropped, next group clean.
    beat(1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("busy_mid_group", longint'(bus.busy), 1);
    beat(1'b1, 8, 1'b0, 0, 1'b0, 0, 1'b0);
    beat(1'b1, 9, 1'b1, 0, 1'b1, 0, 1'b0);
    chk("busy_after_flush", longint'(bus.busy), 0);
    idle(3);
    chk("hold_fixed_after_flush", longint'(bus.fixed_out), longint'(ACC_MIN_SYM));
    chk("hold_sat_after_flush", longint'(bus.sat_flag), 1);
    beat(1'b1, 4, 1'b1, 0, 1'b0, 4, 1'b0);
    idle(1);
    drain();

    // Last term already in stage 0 when flush arrives is discarded too.
    beat(1'b1, 20, 1'b1, 0, 1'b0, 0, 1'b0);
    void'(scb.pop_back());
    beat(1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0);
    idle(3);
    chk("hold_fixed_stage0_flush", longint'(bus.fixed_out), 4);

    // Bubbles of varying length do not disturb the sum.
    idle(5);
    beat(1'b1, 3, 1'b0, 100, 1'b0, 0, 1'b0);
    beat(1'b1, 4, 1'b0, 0, 1'b0, 0, 1'b0);
    idle(2);
    beat(1'b1, 5, 1'b1, 0, 1'b0, 112, 1'b0);
    idle(1);
    drain();

    // Async reset between terms 2 and 3: outputs clear at once, no pulse, fresh bias after.
    beat(1'b1, 3, 1'b0, 100, 1'b0, 0, 1'b0);
    beat(1'b1, 4, 1'b0, 0, 1'b0, 0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_fixed_out", longint'(bus.fixed_out), 0);
    chk("midrst_sat_flag", longint'(bus.sat_flag), 0);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_busy", longint'(bus.busy), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    beat(1'b1, 5, 1'b1, 50, 1'b0, 55, 1'b0);
    idle(1);
    drain();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
